line_rng_pad: RTL and testbench
===============================

Name: line_rng_pad

Overview:
- Horizontal window generator; successor to the line-range stage.
- Accepts one vertical kernel column (KRNV_SZ pixels) per valid cycle and emits a KRNV_SZ x KRNH_SZ window centred on every input pixel.
- Emits exactly W windows per line of W pixels; out-of-image columns are filled per a runtime border mode.
- Sits between the line buffer and the 2-D filter core.

Parameters:
- DBUF_DW, 8, pixel bit width.
- KRNV_SZ, 6, vertical kernel size (pixels per input column).
- KRNH_SZ, 5, horizontal window size; odd, >=3. H = (KRNH_SZ-1)/2.
- IMG_HW_WTH, 12, line pixel counter width; max W = 2^IMG_HW_WTH-1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- i_data, input, DBUF_DW*KRNV_SZ, input column.
- i_href, input, 1, column valid.
- i_hstr, input, 1, first column of line; qualified by i_href.
- i_hend, input, 1, last column of line; qualified by i_href.
- i_vstr, input, 1, frame start; coincident with i_hstr of the first line.
- i_vend, input, 1, frame end; coincident with i_hend of the last line.
- i_pad_mode, input, 2, 0=zero, 1=replicate, 2=mirror, 3=reserved (treated as replicate); sampled at i_hstr.
- o_data, output, DBUF_DW*KRNV_SZ*KRNH_SZ, window; slice k = column x+H-k (slice 0 newest).
- o_dvld, output, 1, window valid.
- o_hstr, output, 1, first window of line.
- o_hend, output, 1, last window of line.
- o_vstr, output, 1, with o_hstr of the first frame line.
- o_vend, output, 1, with o_hend of the last frame line.
- o_ovf, output, 1, one-cycle pulse: i_hstr arrived before the flush completed.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in IDLE; column shift register, pixel counter and flush counter cleared.
  - Mode register resets to 1 (replicate).
- Reset mid-line: line discarded; no partial windows emitted after release.
- Shift register: KRNH_SZ columns; shifts in i_data on i_href, newest at LSB.
- FSM states and transitions:
  - IDLE -> FILL on i_href&i_hstr. Latch mode; pixel counter = 1.
  - FILL: accepts the first H columns without output. -> RUN when column H is accepted.
  - RUN: each accepted column x+H produces window x. -> FLUSH on i_href&i_hend.
  - FLUSH: H cycles, one window per cycle, no input consumed; shift inserts a dummy column. -> IDLE when the flush counter reaches H.
  - FILL with i_hend (short line, W<=H) -> FLUSH. Emit all W windows; mirror degrades to replicate for that line.
- Latency (all outputs registered, one stage):
  - Window x is valid the cycle after column x+H is accepted.
  - Flush windows appear on cycles hend+2 .. hend+H+1, contiguous.
- Padding, for window column index c = x-H+k' outside 0..W-1:
  - zero: pixel value 0.
  - replicate: c<0 -> 0; c>W-1 -> W-1.
  - mirror: c<0 -> -c; c>W-1 -> 2(W-1)-c. Requires W>H, else replicate.
  - Selection uses the pixel counter, the latched W (captured at i_hend) and the resident columns; no extra storage beyond the KRNH_SZ columns.
- i_href gaps in FILL/RUN: state held; no output on gap cycles. o_dvld follows accepted columns with 1-cycle latency.
- Line spacing:
  - Next i_hstr is legal no earlier than hend+H+1.
  - i_hstr in FLUSH: pulse o_ovf, abort the remaining flush windows, start the new line in FILL. o_hend of the aborted line is not emitted.
- o_vstr / o_vend: latched at input and re-emitted with the corresponding o_hstr / o_hend.
- Pixel counter saturates at 2^IMG_HW_WTH-1; longer lines are unsupported.

Decomposition:
- Shared package line_rng_pkg holds:
  - padding mode encodings PAD_ZERO/PAD_REPL/PAD_MIRR;
  - FSM one-hot state constants IDLE/FILL/RUN/FLUSH;
  - the H derivation function.
- One sub-module, line_rng_pad_sel: combinational per-slot column index / pad-select (mode, x, W, k -> source slot or zero), instantiated KRNH_SZ times via generate.

Test Plan:
- Common setup: KRNV_SZ=1, KRNH_SZ=5, DBUF_DW=8; line W=6, data 10..15, continuous i_href.
- Zero mode: window 0 slices4..0 = 0,0,10,11,12; window 5 = 13,14,15,0,0.
  - o_hstr is 3 cycles after i_hstr.
  - o_hend is 3 cycles after i_hend.
  - Exactly 6 o_dvld.
- Replicate: window 0 = 10,10,10,11,12; window 5 = 13,14,15,15,15.
- Mirror: window 0 = 12,11,10,11,12; window 5 = 13,14,15,14,13. Two-line frame: o_vstr only on line 1 o_hstr, o_vend only on line 2 o_hend.
- Short line W=2 (10,11), mirror selected: windows 10,10,10,11,11 and 10,10,11,11,11; o_hstr and o_hend on separate flush cycles.
- i_href toggled 1010..., replicate: identical window values to the continuous case; o_dvld count 6.
- Protocol and reset:
  - i_hstr at hend+2 -> o_ovf pulse 1 cycle; new line output correct; no o_hend for the aborted line.
  - rst_n low mid-RUN -> all outputs 0, next line clean.

Source files
------------

// File: rtl/line_rng_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_rng_pkg
// Brief    : Shared pad-mode encodings, FSM states and half-width helper for
//            the line_rng_pad horizontal window generator.
// Revision : 1.0
// ============================================================================
package line_rng_pkg;

  localparam logic [1:0] PAD_ZERO = 2'd0;
  localparam logic [1:0] PAD_REPL = 2'd1;
  localparam logic [1:0] PAD_MIRR = 2'd2;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    FILL  = 4'b0010,
    RUN   = 4'b0100,
    FLUSH = 4'b1000
  } state_t;

  function automatic int calc_h(input int krnh_sz);
    return (krnh_sz - 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_rng_pad_sel.sv
`default_nettype none
// ============================================================================
// Module   : line_rng_pad_sel
// Brief    : Per-slot source selection: maps a window slot to the resident
//            shift-register slot that holds its (possibly padded) column.
// Revision : 1.0
// ============================================================================
module line_rng_pad_sel
  import line_rng_pkg::*;
#(
  parameter int KRNH_SZ    = 5,
  parameter int IMG_HW_WTH = 12,
  parameter int SLOT       = 0,
  parameter int SW         = $clog2(KRNH_SZ)
) (
  input  logic [1:0]            i_mode,
  input  logic [IMG_HW_WTH-1:0] i_pos,
  input  logic [IMG_HW_WTH-1:0] i_wid,
  input  logic                  i_wknown,
  output logic [SW-1:0]         o_slot,
  output logic                  o_zero
);

  localparam int c_h  = calc_h(KRNH_SZ);
  localparam int c_sn = IMG_HW_WTH + 3;
  localparam logic signed [c_sn-1:0] c_slot = c_sn'(SLOT);
  localparam logic signed [c_sn-1:0] c_one  = c_sn'(1);
  localparam logic signed [c_sn-1:0] c_zero = '0;

  logic signed [c_sn-1:0] w_pos;
  logic signed [c_sn-1:0] w_col;
  logic signed [c_sn-1:0] w_wm1;
  logic signed [c_sn-1:0] w_slot;
  logic                   w_zero_mode;
  logic                   w_mirr;
  logic [c_sn-SW-1:0]     w_unused_slot_hi;

  // Slot k nominally holds column pos-k; column m lives in slot pos-m.
  assign w_pos       = $signed({3'b000, i_pos});
  assign w_col       = w_pos - c_slot;
  assign w_wm1       = $signed({3'b000, i_wid}) - c_one;
  assign w_zero_mode = (i_mode == PAD_ZERO);
  // Before the line end is known every emitted window implies W>H.
  assign w_mirr      = (i_mode == PAD_MIRR) &&
                       (!i_wknown || (i_wid > IMG_HW_WTH'(c_h)));

  always_comb begin
    o_zero = 1'b0;
    w_slot = c_slot;
    if (w_col < c_zero) begin
      if (w_zero_mode) begin
        o_zero = 1'b1;
      end else if (w_mirr) begin
        w_slot = w_pos + w_col;
      end else begin
        w_slot = w_pos;
      end
    end else if (i_wknown && (w_col > w_wm1)) begin
      if (w_zero_mode) begin
        o_zero = 1'b1;
      end else if (w_mirr) begin
        w_slot = w_pos - (w_wm1 <<< 1) + w_col;
      end else begin
        w_slot = w_pos - w_wm1;
      end
    end
  end

  assign o_slot           = w_slot[SW-1:0];
  assign w_unused_slot_hi = w_slot[c_sn-1:SW];

endmodule
`default_nettype wire

// File: rtl/line_rng_pad.sv
`default_nettype none
// ============================================================================
// Module   : line_rng_pad
// Brief    : Horizontal window generator with runtime border padding; emits
//            one KRNV_SZ x KRNH_SZ window per input pixel of each line.
// Revision : 1.0
// ============================================================================
module line_rng_pad
  import line_rng_pkg::*;
#(
  parameter int DBUF_DW    = 8,
  parameter int KRNV_SZ    = 6,
  parameter int KRNH_SZ    = 5,
  parameter int IMG_HW_WTH = 12
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DBUF_DW*KRNV_SZ-1:0]          i_data,
  input  logic                                i_href,
  input  logic                                i_hstr,
  input  logic                                i_hend,
  input  logic                                i_vstr,
  input  logic                                i_vend,
  input  logic [1:0]                          i_pad_mode,
  output logic [DBUF_DW*KRNV_SZ*KRNH_SZ-1:0]  o_data,
  output logic                                o_dvld,
  output logic                                o_hstr,
  output logic                                o_hend,
  output logic                                o_vstr,
  output logic                                o_vend,
  output logic                                o_ovf
);

  localparam int c_h  = calc_h(KRNH_SZ);
  localparam int c_cw = DBUF_DW * KRNV_SZ;
  localparam int c_sw = $clog2(KRNH_SZ);
  localparam int c_fw = $clog2(c_h + 1);
  localparam logic [IMG_HW_WTH-1:0] c_cnt_max    = '1;
  localparam logic [IMG_HW_WTH-1:0] c_one        = IMG_HW_WTH'(1);
  localparam logic [IMG_HW_WTH-1:0] c_pos_h      = IMG_HW_WTH'(c_h);
  localparam logic [c_fw-1:0]       c_flush_last = c_fw'(c_h - 1);

  state_t                       r_state;
  logic [c_cw-1:0]              r_sr     [KRNH_SZ];
  logic [c_cw-1:0]              w_sr_nxt [KRNH_SZ];
  logic [IMG_HW_WTH-1:0]        r_cnt;
  logic [IMG_HW_WTH-1:0]        r_wid;
  logic [c_fw-1:0]              r_fcnt;
  logic [1:0]                   r_mode;
  logic                         r_vstr;
  logic                         r_vend;

  logic [IMG_HW_WTH-1:0]        w_cnt_nxt;
  logic [IMG_HW_WTH-1:0]        w_pos;
  logic                         w_acc;
  logic                         w_start;
  logic                         w_flush;
  logic                         w_shift;
  logic                         w_emit;
  logic                         w_first;
  logic                         w_last;
  logic                         w_wknown;
  logic [c_cw*KRNH_SZ-1:0]      w_win;

  assign w_acc    = i_href && ((r_state == FILL) || (r_state == RUN));
  assign w_start  = i_href && i_hstr && ((r_state == IDLE) || (r_state == FLUSH));
  assign w_flush  = (r_state == FLUSH) && !w_start;
  assign w_shift  = w_acc || w_start || w_flush;
  assign w_wknown = (r_state == FLUSH);

  // Flush cycles count as dummy columns so window x stays at pos-H.
  assign w_cnt_nxt = w_start              ? c_one :
                     (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_one;
  assign w_pos     = w_cnt_nxt - c_one;
  assign w_emit    = (w_acc || w_flush) && (w_pos >= c_pos_h);
  assign w_first   = (w_pos == c_pos_h);
  assign w_last    = w_flush && (r_fcnt == c_flush_last);

  assign w_sr_nxt[0] = w_flush ? '0 : i_data;

  generate
    for (genvar k = 1; k < KRNH_SZ; k++) begin : g_shift
      assign w_sr_nxt[k] = r_sr[k-1];
    end
  endgenerate

  generate
    for (genvar k = 0; k < KRNH_SZ; k++) begin : g_sel
      logic [c_sw-1:0] w_slot;
      logic            w_zero;

      line_rng_pad_sel #(
        .KRNH_SZ    (KRNH_SZ),
        .IMG_HW_WTH (IMG_HW_WTH),
        .SLOT       (k),
        .SW         (c_sw)
      ) u_sel (
        .i_mode   (r_mode),
        .i_pos    (w_pos),
        .i_wid    (r_wid),
        .i_wknown (w_wknown),
        .o_slot   (w_slot),
        .o_zero   (w_zero)
      );

      assign w_win[k*c_cw +: c_cw] = (w_zero || (int'(w_slot) >= KRNH_SZ)) ?
                                     '0 : w_sr_nxt[w_slot];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '{default: '0};
      r_cnt   <= '0;
      r_wid   <= '0;
      r_fcnt  <= '0;
      r_mode  <= PAD_REPL;
      r_vstr  <= 1'b0;
      r_vend  <= 1'b0;
      o_data  <= '0;
      o_dvld  <= 1'b0;
      o_hstr  <= 1'b0;
      o_hend  <= 1'b0;
      o_vstr  <= 1'b0;
      o_vend  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_dvld <= w_emit;
      o_hstr <= w_emit && w_first;
      o_hend <= w_emit && w_last;
      o_vstr <= w_emit && w_first && r_vstr;
      o_vend <= w_emit && w_last && r_vend;
      o_ovf  <= w_start && (r_state == FLUSH);
      if (w_emit) begin
        o_data <= w_win;
      end
      if (w_shift) begin
        r_sr  <= w_sr_nxt;
        r_cnt <= w_cnt_nxt;
      end
      // A new line pre-empts whatever flush is still pending.
      if (w_start) begin
        r_mode <= i_pad_mode;
        r_vstr <= i_vstr;
        r_fcnt <= '0;
        if (i_hend) begin
          r_state <= FLUSH;
          r_wid   <= w_cnt_nxt;
          r_vend  <= i_vend;
        end else begin
          r_state <= FILL;
        end
      end else begin
        case (r_state)
          IDLE: begin
          end
          FILL, RUN: begin
            if (w_acc) begin
              if (i_hend) begin
                r_state <= FLUSH;
                r_wid   <= w_cnt_nxt;
                r_vend  <= i_vend;
                r_fcnt  <= '0;
              end else if (w_first) begin
                r_state <= RUN;
              end
            end
          end
          FLUSH: begin
            r_fcnt <= r_fcnt + c_fw'(1);
            if (r_fcnt == c_flush_last) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_rng_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_rng_pad
// Brief    : Scoreboard bench for line_rng_pad (KRNV_SZ=1, KRNH_SZ=5, 8-bit).
// Revision : 1.0
// ============================================================================
module tb_line_rng_pad;

  localparam int DW = 8;
  localparam int KV = 1;
  localparam int KH = 5;
  localparam int IW = 12;
  localparam int H  = 2;
  localparam int OW = DW * KV * KH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [DW*KV-1:0] i_data = '0;
  logic            i_href = 1'b0;
  logic            i_hstr = 1'b0;
  logic            i_hend = 1'b0;
  logic            i_vstr = 1'b0;
  logic            i_vend = 1'b0;
  logic [1:0]      i_pad_mode = 2'd0;
  logic [OW-1:0]   o_data;
  logic            o_dvld, o_hstr, o_hend, o_vstr, o_vend, o_ovf;

  line_rng_pad #(
    .DBUF_DW    (DW),
    .KRNV_SZ    (KV),
    .KRNH_SZ    (KH),
    .IMG_HW_WTH (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     (i_data),
    .i_href     (i_href),
    .i_hstr     (i_hstr),
    .i_hend     (i_hend),
    .i_vstr     (i_vstr),
    .i_vend     (i_vend),
    .i_pad_mode (i_pad_mode),
    .o_data     (o_data),
    .o_dvld     (o_dvld),
    .o_hstr     (o_hstr),
    .o_hend     (o_hend),
    .o_vstr     (o_vstr),
    .o_vend     (o_vend),
    .o_ovf      (o_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [OW-1:0] data;
    logic [3:0]    flags;
    int            cyc;
    int            x;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_err = 0, n_exp = 0, n_dvld = 0, n_ovf = 0;
  int ovf_cyc = -1;
  int last_t0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference window from the border rules on column index c = x+H-k.
  function automatic logic [OW-1:0] model_win(input int mode, input int w, input int x, input int base);
    logic [OW-1:0] r;
    int c;
    logic [7:0] v;
    r = '0;
    for (int k = 0; k < KH; k++) begin
      c = x + H - k;
      if (c >= 0 && c <= w - 1)        v = 8'(base + c);
      else if (mode == 0)              v = 8'd0;
      else if (mode == 2 && w > H)     v = 8'(base + ((c < 0) ? -c : 2 * (w - 1) - c));
      else                             v = 8'(base + ((c < 0) ? 0 : w - 1));
      r[k*DW +: DW] = v;
    end
    return r;
  endfunction

  task automatic set_idle();
    i_href = 1'b0; i_hstr = 1'b0; i_hend = 1'b0;
    i_vstr = 1'b0; i_vend = 1'b0; i_data = 8'hEE;
  endtask

  task automatic run_line(input int w, input int base, input int mode, input int gap,
                          input int vs, input int ve, input int abort, input int post_idle);
    int step, ncyc, j;
    exp_t e;
    step = (gap != 0) ? 2 : 1;
    @(posedge clk); #1;
    last_t0 = cyc;
    for (int x = 0; x < w; x++) begin
      if (!(abort != 0 && x == w - 1)) begin
        e.data  = model_win(mode, w, x, base);
        e.flags = {x == 0, x == w - 1, (vs != 0) && (x == 0), (ve != 0) && (x == w - 1)};
        e.cyc   = (x <= w - 1 - H) ? last_t0 + (x + H) * step + 1
                                   : last_t0 + (w - 1) * step + 1 + (x - (w - 1 - H));
        e.x     = x;
        sb.push_back(e);
        n_exp++;
      end
    end
    ncyc = (w - 1) * step + 1;
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n % step == 0) begin
        j = n / step;
        i_href = 1'b1; i_data = 8'(base + j); i_pad_mode = 2'(mode);
        i_hstr = (j == 0); i_hend = (j == w - 1);
        i_vstr = (vs != 0) && (j == 0); i_vend = (ve != 0) && (j == w - 1);
      end else begin
        set_idle();
      end
    end
    repeat (post_idle) begin @(posedge clk); #1; set_idle(); end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_ovf) begin n_ovf++; ovf_cyc = cyc; end
    if (o_dvld) begin
      n_dvld++;
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_window: got data %0h with empty scoreboard (cycle %0d)", o_data, cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("win%0d_data", e.x), 64'(o_data), 64'(e.data));
        chk($sformatf("win%0d_flags", e.x), 64'({o_hstr, o_hend, o_vstr, o_vend}), 64'(e.flags));
        chk($sformatf("win%0d_cycle", e.x), 64'(cyc), 64'(e.cyc));
      end
    end else if (o_hstr || o_hend || o_vstr || o_vend) begin
      n_chk++; n_err++;
      $display("FAIL stray_flags: got %b expected 0000 (cycle %0d)", {o_hstr, o_hend, o_vstr, o_vend}, cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    set_idle();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({o_dvld, o_hstr, o_hend, o_vstr, o_vend, o_ovf, o_data}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_line(6, 10, 0, 0, 1, 1, 0, 4);   // zero
    run_line(6, 10, 1, 0, 1, 1, 0, 4);   // replicate
    run_line(6, 10, 2, 0, 1, 0, 0, 4);   // mirror, frame line 1
    run_line(6, 10, 2, 0, 0, 1, 0, 4);   // mirror, frame line 2
    run_line(2, 10, 2, 0, 1, 1, 0, 4);   // short line, mirror degrades
    run_line(6, 10, 1, 1, 1, 1, 0, 4);   // replicate with href gaps

    // Next hstr at hend+2 aborts the final flush window.
    run_line(6, 10, 1, 0, 0, 0, 1, 1);
    run_line(6, 20, 2, 0, 0, 0, 0, 4);
    chk("ovf_count", 64'(n_ovf), 64'd1);
    chk("ovf_cycle", 64'(ovf_cyc), 64'(last_t0 + 1));

    // Reset while in RUN after windows 0 and 1.
    @(posedge clk); #1;
    last_t0 = cyc;
    for (int x = 0; x < 2; x++) begin
      e.data = model_win(1, 6, x, 40); e.flags = {x == 0, 1'b0, 1'b0, 1'b0};
      e.cyc = last_t0 + x + H + 1; e.x = x;
      sb.push_back(e); n_exp++;
    end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      i_href = 1'b1; i_data = 8'(40 + j); i_pad_mode = 2'd1; i_hstr = (j == 0);
      i_hend = 1'b0; i_vstr = 1'b0; i_vend = 1'b0;
    end
    @(posedge clk); #1; set_idle();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({o_dvld, o_hstr, o_hend, o_vstr, o_vend, o_ovf, o_data}), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    run_line(6, 30, 0, 0, 1, 1, 0, 4);

    repeat (10) begin @(posedge clk); #1; end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("dvld_count", 64'(n_dvld), 64'(n_exp));
    chk("ovf_total", 64'(n_ovf), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
